seg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for a bank of NUM_DIGITS common-anode seven-segment digits.

---
 rtl/seg_scan_ctrl_pkg.sv | 21 ++
 rtl/seg_scan_ctrl_hex_to_seg.sv | 11 +
 rtl/seg_scan_ctrl.sv | 147 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the seven-segment scan controller:
// FSM state encoding, the all-off pattern and the active-low hex glyph table.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low gfedcba patterns for hex digits 0..F.
  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'b100_0000, 7'b111_1001, 7'b010_0100, 7'b011_0000,
    7'b001_1001, 7'b001_0010, 7'b000_0010, 7'b111_1000,
    7'b000_0000, 7'b001_0000, 7'b000_1000, 7'b000_0011,
    7'b100_0110, 7'b010_0001, 7'b000_0110, 7'b000_1110
  };

endpackage

// File: rtl/seg_scan_ctrl_hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment pattern (bit0=a .. bit6=g).
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = SEG_GLYPH[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for NUM_DIGITS common-anode digits with a
// double-buffered display value. Optional macro: LEADING_ZERO_BLANK_EN.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int CYCLES_PER_DIGIT = 1000,
  parameter int BLANK_CYCLES     = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  output logic [6:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done,
  output scan_state_t             scan_state
);

  localparam int MAX_CYC = (CYCLES_PER_DIGIT > BLANK_CYCLES) ? CYCLES_PER_DIGIT : BLANK_CYCLES;
  localparam int CW      = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
  localparam int DW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(CYCLES_PER_DIGIT - 1);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);

  scan_state_t             state, state_nx;
  logic [CW-1:0]           cnt, cnt_nx;
  logic [DW-1:0]           digit, digit_nx;
  logic [4*NUM_DIGITS-1:0] shadow, active;
  logic [6:0]              seg_nx, glyph;
  logic [NUM_DIGITS-1:0]   an_nx;
  logic                    frame_nx;
  logic [3:0]              nibble;
  logic                    suppress;
  logic                    boundary;

  assign scan_state = state;
  // frame_done is high during the last show cycle, so that cycle is the frame boundary.
  assign boundary   = frame_done && enable;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    digit_nx = digit;
    if (!enable) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      digit_nx = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nx = BLANK;
          cnt_nx   = '0;
          digit_nx = '0;
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_nx = SHOW;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            state_nx = BLANK;
            cnt_nx   = '0;
            digit_nx = (digit == DIGIT_LAST) ? '0 : digit + 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
          digit_nx = '0;
        end
      endcase
    end
  end

  // Outputs are computed from the next state so they register on the transition edge.
  always_comb begin
    nibble = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_nx == DW'(i)) nibble = active[4*i +: 4];
    end
  end

  hex_to_seg u_hex_to_seg (
    .nibble (nibble),
    .seg_n  (glyph)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lead_zero;

  always_comb begin
    lead_zero = '0;
    lead_zero[NUM_DIGITS-1] = (active[4*NUM_DIGITS-1 -: 4] == 4'h0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      lead_zero[i] = lead_zero[i+1] && (active[4*i +: 4] == 4'h0);
    end
    suppress = (digit_nx != '0) && lead_zero[digit_nx];
  end
`else
  assign suppress = 1'b0;
`endif

  always_comb begin
    an_nx  = '1;
    seg_nx = SEG_BLANK;
    if (state_nx == SHOW) begin
      an_nx[digit_nx] = 1'b0;
      if (!suppress) seg_nx = glyph;
    end
    frame_nx = (state_nx == SHOW) && (digit_nx == DIGIT_LAST) && (cnt_nx == SHOW_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      digit      <= '0;
      shadow     <= '0;
      active     <= '0;
      seg_n      <= SEG_BLANK;
      an_n       <= '1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      digit      <= digit_nx;
      seg_n      <= seg_nx;
      an_n       <= an_nx;
      frame_done <= frame_nx;
      if (load) shadow <= value;
      // A load on the boundary bypasses the shadow so the newest value wins.
      if (load && (state == IDLE || boundary)) active <= value;
      else if (boundary)                       active <= shadow;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with 4 digits, 4-cycle slots and 1 blank cycle.
module tb_seg_scan_ctrl;
  import seg_pkg::*;

  localparam int ND    = 4;
  localparam int CPD   = 4;
  localparam int BLK   = 1;
  localparam int SLOT  = CPD + BLK;
  localparam int FRAME = ND * SLOT;

  logic              clk;
  logic              rst_n;
  logic              enable;
  logic              load;
  logic [4*ND-1:0]   value;
  logic [6:0]        seg_n;
  logic [ND-1:0]     an_n;
  logic              frame_done;
  scan_state_t       scan_state;

  logic [11:0]       exp_q[$];
  logic [15:0]       exp_active;
  logic [15:0]       exp_shadow;
  int                total;
  int                bad;

  seg_scan_ctrl #(
    .NUM_DIGITS       (ND),
    .CYCLES_PER_DIGIT (CPD),
    .BLANK_CYCLES     (BLK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .load       (load),
    .value      (value),
    .seg_n      (seg_n),
    .an_n       (an_n),
    .frame_done (frame_done),
    .scan_state (scan_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h40; 4'h1: glyph = 7'h79; 4'h2: glyph = 7'h24; 4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19; 4'h5: glyph = 7'h12; 4'h6: glyph = 7'h02; 4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00; 4'h9: glyph = 7'h10; 4'hA: glyph = 7'h08; 4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46; 4'hD: glyph = 7'h21; 4'hE: glyph = 7'h06; default: glyph = 7'h0E;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks frame positions 0..stop-1; optional loads a/b are driven in cycle pa/pb.
  task automatic run_frame(input int pa, input logic [15:0] va,
                           input int pb, input logic [15:0] vb, input int stop);
    int          slot;
    int          off;
    logic [3:0]  an_e;
    logic [6:0]  seg_e;
    logic        fd_e;
    logic [11:0] e;
    logic [11:0] got;
    logic [15:0] upper;
    for (int p = 0; p < stop; p++) begin
      slot  = p / SLOT;
      off   = p % SLOT;
      an_e  = 4'hF;
      seg_e = 7'h7F;
      fd_e  = (p == FRAME - 1);
      if (off >= BLK) begin
        an_e  = ~(4'b0001 << slot);
        seg_e = glyph(4'((exp_active >> (4 * slot)) & 16'hF));
`ifdef LEADING_ZERO_BLANK_EN
        upper = exp_active >> (4 * slot);
        if (slot != 0 && upper == 16'h0) seg_e = 7'h7F;
`else
        upper = 16'h0;
`endif
      end
      exp_q.push_back({an_e, seg_e, fd_e});
      step();
      load = 1'b0;
      got  = {an_n, seg_n, frame_done};
      e    = exp_q.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL frame_p%0d act=%0d: an_n=%h seg_n=%h fd=%b, expected an_n=%h seg_n=%h fd=%b",
                 p, exp_active, got[11:8], got[7:1], got[0], e[11:8], e[7:1], e[0]);
      end
      if (p == pa) begin load = 1'b1; value = va; exp_shadow = va; end
      if (p == pb) begin load = 1'b1; value = vb; exp_shadow = vb; end
    end
    if (stop == FRAME) exp_active = exp_shadow;
  endtask

  task automatic check_dark(input string name, input logic want_idle);
    total++;
    if (an_n !== 4'hF || seg_n !== 7'h7F || frame_done !== 1'b0) begin
      bad++;
      $display("FAIL %s: an_n=%h seg_n=%h fd=%b, expected an_n=f seg_n=7f fd=0",
               name, an_n, seg_n, frame_done);
    end
    if (want_idle) begin
      total++;
      if (scan_state !== IDLE) begin
        bad++;
        $display("FAIL %s_state: state=%0d, expected %0d", name, scan_state, IDLE);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; enable = 1'b0; load = 1'b0; value = '0;
    #1 rst_n = 1'b0;
    #1 check_dark("reset", 1'b1);
    exp_active = '0; exp_shadow = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_dark("idle_after_reset", 1'b1);
  endtask

  task automatic test_basic_scan();
    value = 16'h12F0; load = 1'b1;
    step();
    load = 1'b0;
    exp_active = 16'h12F0; exp_shadow = 16'h12F0;
    check_dark("idle_load", 1'b1);
    enable = 1'b1;
    run_frame(-1, 16'h0, -1, 16'h0, FRAME);
    run_frame(-1, 16'h0, -1, 16'h0, FRAME);
  endtask

  task automatic test_no_tearing();
    run_frame(6, 16'h0002, -1, 16'h0, FRAME);
    run_frame(-1, 16'h0, -1, 16'h0, FRAME);
  endtask

  task automatic test_boundary_load();
    run_frame(FRAME - 1, 16'hFFFF, -1, 16'h0, FRAME);
    run_frame(-1, 16'h0, -1, 16'h0, FRAME);
  endtask

  task automatic test_last_load_wins();
    run_frame(3, 16'hABCD, 11, 16'h3456, FRAME);
    run_frame(-1, 16'h0, -1, 16'h0, FRAME);
    run_frame($urandom_range(0, FRAME - 1), 16'($urandom_range(0, 16'hFFFF)), -1, 16'h0, FRAME);
    run_frame(-1, 16'h0, -1, 16'h0, FRAME);
  endtask

  task automatic test_enable_drop();
    run_frame(-1, 16'h0, -1, 16'h0, 2 * SLOT + BLK + 1);
    enable = 1'b0;
    step();
    check_dark("enable_drop", 1'b1);
    step();
    check_dark("enable_low", 1'b1);
    enable = 1'b1;
    run_frame(-1, 16'h0, -1, 16'h0, FRAME);
  endtask

  task automatic test_reset_mid_show();
    run_frame(-1, 16'h0, -1, 16'h0, BLK + 2);
    #2 rst_n = 1'b0;
    #1 check_dark("reset_mid_show", 1'b1);
    exp_active = '0; exp_shadow = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(-1, 16'h0, -1, 16'h0, FRAME);
  endtask

  task automatic test_leading_zero();
    enable = 1'b0;
    step();
    value = 16'h0020; load = 1'b1;
    step();
    load = 1'b0;
    exp_active = 16'h0020; exp_shadow = 16'h0020;
    check_dark("lz_idle", 1'b1);
    enable = 1'b1;
    run_frame(-1, 16'h0, -1, 16'h0, FRAME);
    run_frame(2, 16'h0307, -1, 16'h0, FRAME);
    run_frame(-1, 16'h0, -1, 16'h0, FRAME);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic_scan();
    test_no_tearing();
    test_boundary_load();
    test_last_load_wins();
    test_enable_drop();
    test_reset_mid_show();
    test_leading_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
